pt_write_buffer: RTL
====================

Name: pt_write_buffer

Overview:
- Sits directly downstream of the projective transform, between its pixel-write outputs and the frame-buffer memory interface.
- Buffers transformed pixel writes in a small FIFO and drops writes with off-screen coordinates.
- Issues memory writes with a valid/ack handshake and drives the transform's write-permission flag (ptflag).
- Double-buffers the frame memory: the write bank swaps only after all writes from the finished frame have drained.

Parameters:
- DEPTH, 16, FIFO entries (power of 2, >=4).
- H_ACTIVE, 640, pixels per line; writes with x >= H_ACTIVE are discarded.
- V_ACTIVE, 480, lines per frame; writes with y >= V_ACTIVE are discarded.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- pt_pixel_write  in  18  pixel data from transform
- pt_x  in  10  pixel x coordinate
- pt_y  in  9  pixel y coordinate
- pt_wr  in  1  write strobe, one entry per cycle high
- frame_end  in  1  single-cycle pulse: transform has finished the frame
- ptflag  out  1  registered; transform may issue pt_wr next cycle
- mem_addr  out  20  {bank, y, x}
- mem_data  out  18  pixel data to memory
- mem_we  out  1  write request, held until acked
- mem_ack  in  1  memory accepts the current request this cycle
- display_bank  out  1  bank that is safe to display (the one not being written)
- overflow  out  1  sticky: a write was lost because the FIFO was full
- clip_count  out  16  number of discarded off-screen writes, saturating

Behaviour:
- Reset values (rst_n low, asynchronous): FIFO empty, state RUN, write bank 0, display_bank 1, ptflag 0, mem_we 0, mem_addr 0, mem_data 0, overflow 0, clip_count 0.
- Ingress, each cycle with pt_wr=1:
  - If x >= H_ACTIVE or y >= V_ACTIVE: discard the write; clip_count increments, saturating at 16'hFFFF.
  - Else if the FIFO is full and not popping this cycle: drop the write; set overflow.
  - Else: enqueue {x, y, data}. A push and a pop in the same cycle are both legal; count is unchanged.
- ptflag (registered) = (state==RUN) && (count <= DEPTH-3). This gives one cycle of margin for the transform's registered pt_wr response.
- Egress:
  - When the FIFO is non-empty and no request is outstanding, load head into mem_addr = {write_bank, y, x} and mem_data; assert mem_we the next cycle.
  - Hold mem_we, mem_addr and mem_data stable until the cycle in which mem_ack=1; pop at that edge.
  - Back-to-back: if the FIFO holds more entries at the ack edge, present the next entry on the following cycle with mem_we remaining high. Sustained rate is 1 write/cycle when mem_ack is held high.
  - mem_ack while mem_we=0 is ignored.
- State machine:
  - RUN: normal operation. frame_end -> DRAIN.
  - DRAIN: ptflag=0. pt_wr is still accepted (in-flight writes). When the FIFO is empty and mem_we=0 -> SWAP.
  - SWAP (1 cycle): write_bank toggles; display_bank <= old write_bank; -> RUN. ptflag is re-asserted the following cycle.
- frame_end during DRAIN or SWAP is ignored.
- frame_end coincident with pt_wr: the write belongs to the finishing frame.
- Reset mid-transaction: all pending entries are discarded and mem_we drops immediately (asynchronous).

Optional Feature:
- Macro: PT_WRITE_BUFFER_DUP_MERGE_EN.
- Defined:
  - An incoming on-screen write whose {x, y} equals the most recently enqueued entry overwrites that entry's data in place (no push), provided the entry is still in the FIFO and is not the head being loaded or popped that cycle. Otherwise the write is enqueued normally.
  - Adds output merge_count [15:0], saturating, counting merged writes.
  - This absorbs repeated coordinates from fractional iteration.
- Undefined: every on-screen write is enqueued; merge_count is absent.

Test Plan:
- Reset, then pt_wr with x=5, y=3, data=18'h2A5A, mem_ack tied 1 -> mem_we for exactly one cycle; mem_addr = {1'b0, 9'd3, 10'd5}; mem_data = 18'h2A5A; ptflag = 1.
- pt_wr with x=640, y=0, then x=0, y=480 -> no mem_we; clip_count = 2.
- mem_ack held 0, 14 writes honouring ptflag -> ptflag falls when count reaches 14 (DEPTH-2); no overflow. Forcing 3 further writes while the FIFO is full -> overflow = 1, and only 16 writes emerge once mem_ack=1, in order.
- 4 writes queued, frame_end pulse, mem_ack=1 -> 4 writes with bank bit 0, then SWAP: display_bank 1->0; the next write uses bank bit 1.
- frame_end with the FIFO empty and idle -> DRAIN 1 cycle, SWAP 1 cycle, ptflag back to 1 by the 3rd cycle; a second frame_end during DRAIN causes no extra swap.
- With PT_WRITE_BUFFER_DUP_MERGE_EN, mem_ack=0: writes (7,7,A), (7,7,B), (8,7,C) -> count 2; after ack, memory receives B@(7,7) then C@(8,7); merge_count = 1.

Source files
------------

// File: rtl/pt_write_buffer.sv
// Write buffer between the projective transform and frame-buffer memory: clips off-screen writes,
// queues the rest and double-buffers banks. Optional macro PT_WRITE_BUFFER_DUP_MERGE_EN.
module pt_write_buffer #(
   parameter int unsigned DEPTH    = 16,
   parameter int unsigned H_ACTIVE = 640,
   parameter int unsigned V_ACTIVE = 480
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [17:0] pt_pixel_write,
   input  logic [9:0]  pt_x,
   input  logic [8:0]  pt_y,
   input  logic        pt_wr,
   input  logic        frame_end,
   output logic        ptflag,
   output logic [19:0] mem_addr,
   output logic [17:0] mem_data,
   output logic        mem_we,
   input  logic        mem_ack,
   output logic        display_bank,
   output logic        overflow,
   output logic [15:0] clip_count
`ifdef PT_WRITE_BUFFER_DUP_MERGE_EN
   ,
   output logic [15:0] merge_count
`endif
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam logic [CW-1:0] Full    = CW'(DEPTH);
   localparam logic [CW-1:0] FlagMax = CW'(DEPTH - 3);

   typedef enum logic [1:0] {StRun, StDrain, StSwap} state_e;

   state_e          state_q, state_d;
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, next_idx;
   logic [CW-1:0]   count_q, count_d;
   logic            mem_we_q, mem_we_d;
   logic [19:0]     mem_addr_q, mem_addr_d;
   logic [17:0]     mem_data_q, mem_data_d;
   logic            write_bank_q, write_bank_d;
   logic            display_bank_q, display_bank_d;
   logic            ptflag_q, ptflag_d;
   logic            overflow_q, overflow_d;
   logic [15:0]     clip_count_q, clip_count_d;

   logic [9:0]      fifo_x [DEPTH];
   logic [8:0]      fifo_y [DEPTH];
   logic [17:0]     fifo_d [DEPTH];

   logic            on_screen, pop, load_idle, push, merge, merge_head;

`ifdef PT_WRITE_BUFFER_DUP_MERGE_EN
   logic [AW-1:0]   last_idx;
   logic [15:0]     merge_count_q, merge_count_d;
`endif

   always_comb begin
      on_screen  = (32'(pt_x) < H_ACTIVE) && (32'(pt_y) < V_ACTIVE);
      pop        = mem_we_q && mem_ack;
      load_idle  = !mem_we_q && (count_q != '0);
      next_idx   = rd_ptr_q + 1'b1;
      merge      = 1'b0;
      merge_head = 1'b0;
`ifdef PT_WRITE_BUFFER_DUP_MERGE_EN
      last_idx = wr_ptr_q - 1'b1;
      // The newest entry may be merged unless it is the head being loaded or popped right now.
      merge = pt_wr && on_screen && (count_q != '0) &&
              (fifo_x[last_idx] == pt_x) && (fifo_y[last_idx] == pt_y) &&
              !((last_idx == rd_ptr_q) && (load_idle || pop)) &&
              !(pop && (count_q > CW'(1)) && (last_idx == next_idx));
      // A presented-but-unacked head holds its data only in the output register too.
      merge_head = merge && mem_we_q && (last_idx == rd_ptr_q);
`endif
      push = pt_wr && on_screen && !merge && ((count_q != Full) || pop);
   end

   always_comb begin
      state_d        = state_q;
      wr_ptr_d       = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d       = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
      count_d        = count_q;
      mem_we_d       = mem_we_q;
      mem_addr_d     = mem_addr_q;
      mem_data_d     = mem_data_q;
      write_bank_d   = write_bank_q;
      display_bank_d = display_bank_q;
      overflow_d     = overflow_q;
      clip_count_d   = clip_count_q;

      if (push && !pop) begin
         count_d = count_q + 1'b1;
      end else if (pop && !push) begin
         count_d = count_q - 1'b1;
      end

      if (pt_wr && !on_screen && (clip_count_q != 16'hFFFF)) begin
         clip_count_d = clip_count_q + 16'd1;
      end
      if (pt_wr && on_screen && !merge && (count_q == Full) && !pop) begin
         overflow_d = 1'b1;
      end

      if (load_idle) begin
         mem_we_d   = 1'b1;
         mem_addr_d = {write_bank_q, fifo_y[rd_ptr_q], fifo_x[rd_ptr_q]};
         mem_data_d = fifo_d[rd_ptr_q];
      end else if (pop) begin
         if (count_q > CW'(1)) begin
            mem_addr_d = {write_bank_q, fifo_y[next_idx], fifo_x[next_idx]};
            mem_data_d = fifo_d[next_idx];
         end else begin
            mem_we_d = 1'b0;
         end
      end else if (merge_head) begin
         mem_data_d = pt_pixel_write;
      end

      unique case (state_q)
         StRun: begin
            if (frame_end) state_d = StDrain;
         end
         StDrain: begin
            // A write landing in the empty cycle still belongs to the old frame.
            if ((count_q == '0) && !mem_we_q && !push) state_d = StSwap;
         end
         StSwap: begin
            write_bank_d   = ~write_bank_q;
            display_bank_d = write_bank_q;
            state_d        = StRun;
         end
         default: state_d = StRun;
      endcase

      ptflag_d = (state_d == StRun) && (count_d <= FlagMax);
   end

`ifdef PT_WRITE_BUFFER_DUP_MERGE_EN
   always_comb begin
      merge_count_d = merge_count_q;
      if (merge && (merge_count_q != 16'hFFFF)) merge_count_d = merge_count_q + 16'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) merge_count_q <= '0;
      else        merge_count_q <= merge_count_d;
   end

   assign merge_count = merge_count_q;
`endif

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_x[wr_ptr_q] <= pt_x;
         fifo_y[wr_ptr_q] <= pt_y;
         fifo_d[wr_ptr_q] <= pt_pixel_write;
      end
`ifdef PT_WRITE_BUFFER_DUP_MERGE_EN
      if (merge) fifo_d[last_idx] <= pt_pixel_write;
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= StRun;
         wr_ptr_q       <= '0;
         rd_ptr_q       <= '0;
         count_q        <= '0;
         mem_we_q       <= 1'b0;
         mem_addr_q     <= '0;
         mem_data_q     <= '0;
         write_bank_q   <= 1'b0;
         display_bank_q <= 1'b1;
         ptflag_q       <= 1'b0;
         overflow_q     <= 1'b0;
         clip_count_q   <= '0;
      end else begin
         state_q        <= state_d;
         wr_ptr_q       <= wr_ptr_d;
         rd_ptr_q       <= rd_ptr_d;
         count_q        <= count_d;
         mem_we_q       <= mem_we_d;
         mem_addr_q     <= mem_addr_d;
         mem_data_q     <= mem_data_d;
         write_bank_q   <= write_bank_d;
         display_bank_q <= display_bank_d;
         ptflag_q       <= ptflag_d;
         overflow_q     <= overflow_d;
         clip_count_q   <= clip_count_d;
      end
   end

   assign ptflag       = ptflag_q;
   assign mem_addr     = mem_addr_q;
   assign mem_data     = mem_data_q;
   assign mem_we       = mem_we_q;
   assign display_bank = display_bank_q;
   assign overflow     = overflow_q;
   assign clip_count   = clip_count_q;

endmodule
